fir_result_reader: RTL

//  Consumer end of the FIR filter's floatType result stream. Runs on the fast clock and takes one

---
 rtl/fir_result_reader_pkg.sv | 20 ++
 rtl/fir_result_reader_sync_fifo.sv | 69 ++++++
 rtl/fir_result_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fir_result_reader_pkg.sv
// Shared types and constants for the FIR result reader.
// floatType is the FIR result word; the warm-up default tracks the FIR taps.
package CbfPkg;

  typedef logic [31:0] floatType;

  typedef enum logic {
    S_WARMUP,
    S_RUN
  } reader_state_t;

  localparam int FIR_LOOKAHEAD    = 240;
  localparam int FIR_LOOKBACK     = 240;
  localparam int FIR_ADDER_LAYERS = 9;

  localparam int WARMUP_DEFAULT =
    FIR_LOOKAHEAD + FIR_LOOKBACK +
    FIR_ADDER_LAYERS + 1;

endpackage

// File: rtl/fir_result_reader_sync_fifo.sv
// Synchronous FIFO with separate occupancy count.
// Push while full is accepted only alongside a pop.
module sync_fifo
  import CbfPkg::*;
#(
  parameter int DEPTH = 16,
  parameter int FW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [FW-1:0]          wdata,
  output logic [FW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [FW-1:0] mem_q [DEPTH];
  logic [FW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          do_push, do_pop;

  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == (AW+1)'(DEPTH));
  assign level = lvl_q;
  assign rdata = mem_q[rd_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d = wr_q + AW'(1);
    end
    if (do_pop)
      rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)
      lvl_d = lvl_q + (AW+1)'(1);
    else if (do_pop && !do_push)
      lvl_d = lvl_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/fir_result_reader.sv
// FIR result consumer: drops warm-up results, buffers the rest.
// Define CBF_SERIAL_EN to replace valid/ready output with a serializer.
module fir_result_reader
  import CbfPkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WARMUP = WARMUP_DEFAULT,
  parameter int FW     = $bits(floatType)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [FW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FW-1:0]          out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   warm,
`ifdef CBF_SERIAL_EN
  output logic                   ser_data,
  output logic                   ser_frame,
`endif
  output logic                   overflow
);

  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam reader_state_t ST_RST =
    (WARMUP == 0) ? S_RUN : S_WARMUP;

  reader_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          warm_q, warm_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic          full, empty;
  logic [FW-1:0] head;

  sync_fifo #(.DEPTH(DEPTH), .FW(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign push     = (state_q == S_RUN) && in_valid;
  assign out_data = head;
  assign warm     = warm_q;
  assign overflow = ovf_q;

`ifdef CBF_SERIAL_EN
  localparam int BW = $clog2(FW);

  logic          busy_q, busy_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FW-1:0] sh_q, sh_d;
  logic          last_bit;
  logic          unused_ready;

  assign unused_ready = out_ready;
  assign out_valid    = 1'b0;
  assign last_bit     = (bit_q == BW'(FW-1));
  assign pop          = (!busy_q || last_bit) && !empty;
  assign ser_data     = busy_q && sh_q[FW-1];
  assign ser_frame    = busy_q && (bit_q == '0);

  always_comb begin
    busy_d = busy_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    if (pop) begin
      busy_d = 1'b1;
      bit_d  = '0;
      sh_d   = head;
    end else if (busy_q) begin
      busy_d = !last_bit;
      bit_d  = bit_q + BW'(1);
      sh_d   = {sh_q[FW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else begin
      busy_q <= busy_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
    end
  end
`else
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == S_WARMUP): begin
        if (in_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WARMUP-1))
            state_d = S_RUN;
        end
      end
      default: begin
        if (push && full && !pop)
          ovf_d = 1'b1;
      end
    endcase
    warm_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      warm_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
